mini_alu_core: RTL



---
 rtl/mini_alu_core.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mini_alu_core.sv
// Two-phase (fetch/execute) mini ALU engine with a parametrised register file,
// an external instruction-ROM port and an iterative radix-2 Booth signed multiplier.
module mini_alu_core #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IP_WIDTH   = 16,
    parameter int LED_WIDTH  = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    output logic [IP_WIDTH-1:0]       oIP,
    input  logic [4+3*ADDR_WIDTH-1:0] iInstruction,
    output logic [LED_WIDTH-1:0]      oLed,
    output logic                      oBusy
);

    localparam int W           = DATA_WIDTH;
    localparam int INSTR_WIDTH = 4 + 3*ADDR_WIDTH;
    localparam int DEPTH       = 2**ADDR_WIDTH;
    localparam int IMM_W       = 2*ADDR_WIDTH;
    localparam int EXT_W       = (IMM_W > W) ? IMM_W : W;
    localparam int CNT_W       = $clog2(W);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_STO  = 4'd3;
    localparam logic [3:0] OP_BLE  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_LED  = 4'd6;
    localparam logic [3:0] OP_SMUL = 4'd7;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MUL, ST_WB_HI} state_t;

    state_t                 state_q;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [IP_WIDTH-1:0]    ip_q;
    logic [LED_WIDTH-1:0]   led_q;
    logic                   busy_q;
    logic [W:0]             mul_m_q;
    logic [W:0]             mul_acc_q;
    logic [W-1:0]           mul_q_q;
    logic                   mul_qm1_q;
    logic [CNT_W-1:0]       mul_cnt_q;
    logic [W-1:0]           regs_q [DEPTH];

    logic [3:0]            op;
    logic [ADDR_WIDTH-1:0] dest, src1, src0;
    logic [W-1:0]          rd1, rd0, imm;
    logic [EXT_W-1:0]      imm_ext;
    logic                  mul_last;
    logic [W:0]            mul_sum, mul_acc_d;
    logic [W-1:0]          mul_q_d;
    logic                  mul_qm1_d;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [W-1:0]          wr_data;

    assign op       = ir_q[INSTR_WIDTH-1 -: 4];
    assign dest     = ir_q[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign src1     = ir_q[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign src0     = ir_q[ADDR_WIDTH-1:0];
    assign rd1      = regs_q[src1];
    assign rd0      = regs_q[src0];
    assign imm_ext  = EXT_W'({src1, src0});
    assign imm      = imm_ext[W-1:0];
    assign mul_last = (mul_cnt_q == CNT_W'(W-1));

    // Booth step: the extra accumulator bit absorbs -(-2^(W-1)) without overflow.
    always_comb begin
        mul_sum = mul_acc_q;
        case ({mul_q_q[0], mul_qm1_q})
            2'b01:   mul_sum = mul_acc_q + mul_m_q;
            2'b10:   mul_sum = mul_acc_q - mul_m_q;
            default: mul_sum = mul_acc_q;
        endcase
    end

    assign mul_acc_d = {mul_sum[W], mul_sum[W:1]};
    assign mul_q_d   = {mul_sum[0], mul_q_q[W-1:1]};
    assign mul_qm1_d = mul_q_q[0];

    // Single write port; suppressed during reset so an aborted multiply never lands.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = dest;
        wr_data = '0;
        if (!Reset) begin
            case (state_q)
                ST_EXEC: begin
                    case (op)
                        OP_ADD: begin wr_en = 1'b1; wr_data = rd1 + rd0; end
                        OP_SUB: begin wr_en = 1'b1; wr_data = rd1 - rd0; end
                        OP_STO: begin wr_en = 1'b1; wr_data = imm;       end
                        default: ;
                    endcase
                end
                ST_MUL: begin
                    wr_en   = mul_last;
                    wr_data = mul_q_d;
                end
                ST_WB_HI: begin
                    wr_en   = 1'b1;
                    wr_addr = dest + ADDR_WIDTH'(1);
                    wr_data = mul_acc_q[W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) regs_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            ip_q      <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            mul_m_q   <= '0;
            mul_acc_q <= '0;
            mul_q_q   <= '0;
            mul_qm1_q <= 1'b0;
            mul_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    ir_q    <= iInstruction;
                    ip_q    <= ip_q + IP_WIDTH'(1);
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    state_q <= ST_FETCH;
                    case (op)
                        OP_BLE: if (rd1 <= rd0) ip_q <= IP_WIDTH'(dest);
                        OP_JMP: ip_q <= IP_WIDTH'(dest);
                        OP_LED: led_q <= rd1[LED_WIDTH-1:0];
                        OP_SMUL: begin
                            mul_m_q   <= {rd1[W-1], rd1};
                            mul_acc_q <= '0;
                            mul_q_q   <= rd0;
                            mul_qm1_q <= 1'b0;
                            mul_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_MUL;
                        end
                        default: ;
                    endcase
                end
                ST_MUL: begin
                    mul_acc_q <= mul_acc_d;
                    mul_q_q   <= mul_q_d;
                    mul_qm1_q <= mul_qm1_d;
                    mul_cnt_q <= mul_cnt_q + CNT_W'(1);
                    if (mul_last) state_q <= ST_WB_HI;
                end
                ST_WB_HI: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_FETCH;
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    assign oIP   = ip_q;
    assign oLed  = led_q;
    assign oBusy = busy_q;

endmodule
